// File: rtl/id_bypass_scoreboard_pkg.sv
// Shared MIPS32 pipeline definitions: register address width, bypass stage numbering
// and the scoreboard entry layout.
package mips_pipe_pkg;

  localparam int REG_AW        = 5;
  localparam int FWD_DEPTH_DEF = 3;
  localparam int FWD_SRC_RF    = 0;

  localparam int STG_IDEX  = 1;
  localparam int STG_EXMEM = 2;
  localparam int STG_MEMWB = 3;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              ld;
  } sb_entry_t;

endpackage

// File: rtl/id_bypass_scoreboard_if.sv
// ID-stage bypass bus: operand/destination info from decode, select and stall back to it.
interface id_bypass_scoreboard_if #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int SEL_W   = 2
);
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [REG_AW-1:0]         id_rd;
  logic                      id_reg_write;
  logic                      id_is_load;
  logic                      flush;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic                      stall;
  logic [31:0]               stall_cycles;

  modport master (
    output id_valid, id_src, id_src_used, id_rd, id_reg_write, id_is_load, flush,
    input  fwd_sel, stall, stall_cycles
  );

  modport slave (
    input  id_valid, id_src, id_src_used, id_rd, id_reg_write, id_is_load, flush,
    output fwd_sel, stall, stall_cycles
  );
endinterface

// File: rtl/id_bypass_scoreboard_prio_sel.sv
// Per-operand priority encoder: picks the youngest matching stage and reports
// whether that producer's result is still unavailable.
module bypass_prio_sel #(
  parameter int FWD_DEPTH = 3,
  parameter int SEL_W     = 2
) (
  input  logic [FWD_DEPTH-1:0] match,
  input  logic [FWD_DEPTH-1:0] ready,
  output logic [SEL_W-1:0]     sel,
  output logic                 not_ready
);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    sel       = '0;
    not_ready = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (match[k-1]) begin
        sel       = SEL_W'(k);
        not_ready = ~ready[k-1];
      end
    end
  end

endmodule

// File: rtl/id_bypass_scoreboard.sv
// ID-stage operand bypass select and load-use interlock driven by a shift-register
// scoreboard of in-flight destinations, plus a saturating stall-cycle counter.
module id_bypass_scoreboard #(
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = mips_pipe_pkg::FWD_DEPTH_DEF,
  parameter int REG_AW     = mips_pipe_pkg::REG_AW,
  parameter int ALU_READY  = 2,
  parameter int LOAD_READY = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  id_bypass_scoreboard_if.slave sb
);
  import mips_pipe_pkg::*;

  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  if (!(ALU_READY >= 1 && ALU_READY <= LOAD_READY && LOAD_READY <= FWD_DEPTH)) begin : g_bad_ready
    $error("id_bypass_scoreboard: need 1 <= ALU_READY <= LOAD_READY <= FWD_DEPTH");
  end
  if (REG_AW != mips_pipe_pkg::REG_AW) begin : g_bad_aw
    $error("id_bypass_scoreboard: REG_AW must match the pipeline package");
  end

  logic [FWD_DEPTH-1:0] v_q;
  logic [FWD_DEPTH-1:0] ld_q;
  logic [REG_AW-1:0]    rd_q [FWD_DEPTH];
  logic [FWD_DEPTH-1:0] rdy;
  logic [NUM_SRC-1:0]   nr;
  logic [NUM_SRC*SEL_W-1:0] sel_all;
  logic                 stall;
  logic [31:0]          stall_cnt;
  logic [31:0]          stall_cnt_nxt;
  sb_entry_t            ent_in;

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  // Stalled or flushed instructions enter as bubbles; r0 is never tracked.
  always_comb begin
    ent_in.v  = sb.id_valid & sb.id_reg_write & (sb.id_rd != '0) & ~stall & ~sb.flush;
    ent_in.rd = sb.id_rd;
    ent_in.ld = sb.id_is_load;
  end

  // Stage boundary: ID -> scoreboard entry 1, entry k -> entry k+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
    end else begin
      for (int k = FWD_DEPTH - 1; k >= 1; k--) v_q[k] <= v_q[k-1];
      v_q[STG_IDEX-1] <= ent_in.v;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
      rd_q[k] <= rd_q[k-1];
      ld_q[k] <= ld_q[k-1];
    end
    rd_q[STG_IDEX-1] <= ent_in.rd;
    ld_q[STG_IDEX-1] <= ent_in.ld;
  end

  always_comb begin
    rdy = '0;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      rdy[k] = ld_q[k] ? ((k + 1) >= LOAD_READY) : ((k + 1) >= ALU_READY);
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_AW-1:0]    src;
    logic [FWD_DEPTH-1:0] match;
    logic [SEL_W-1:0]     sel;

    assign src = sb.id_src[i*REG_AW +: REG_AW];

    always_comb begin
      match = '0;
      for (int k = 0; k < FWD_DEPTH; k++) begin
        match[k] = sb.id_src_used[i] & v_q[k] & (rd_q[k] == src) & (src != '0);
      end
    end

    bypass_prio_sel #(
      .FWD_DEPTH (FWD_DEPTH),
      .SEL_W     (SEL_W)
    ) u_sel (
      .match     (match),
      .ready     (rdy),
      .sel       (sel),
      .not_ready (nr[i])
    );

    assign sel_all[i*SEL_W +: SEL_W] = sel;
  end

  // Flush squashes the ID instruction, so it can never be held.
  assign stall         = sb.id_valid & ~sb.flush & (|nr);
  assign stall_cnt_nxt = stall ? sat_inc(stall_cnt) : stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) stall_cnt <= '0;
    else       stall_cnt <= stall_cnt_nxt;
  end

  assign sb.fwd_sel      = sel_all;
  assign sb.stall        = stall;
  assign sb.stall_cycles = stall_cnt;

endmodule
